// File: rtl/spi_reg_bank_pkg.sv
// spi_reg_pkg: shared constants, the frame state type and an address range helper.
// Latency: none (types and constants only).
// Backpressure: none.
package spi_reg_pkg;

  localparam int CMD_BITS      = 8;
  localparam int CMD_WRITE_BIT = 7;
  localparam int ADDR_BITS     = 7;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } spi_state_t;

  // True when a 7-bit command address selects an implemented register.
  function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr, input int nregs);
    return int'(addr) < nregs;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: SPI pin bundle between the MCU (master) and the register bank (slave).
// Latency: none (wiring only).
// Backpressure: none; SPI has no flow control beyond chip select.
// Signals: sclk, cs (active-low), mosi driven by the master; miso driven by the slave.
interface spi_reg_bank_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_reg_bank_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer plus one history flop for edge detection.
// Latency: level valid 2 clk after the pin, rise/fall pulses visible during the 3rd clk.
// Backpressure: none.
// Ports: clk, rst_n (sync, active-low), din (async pin) -> level, rise, fall (one-cycle pulses).
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // Flops reset to 0: a chip select already high when reset releases is seen
  // as a rise while IDLE (harmless), while one still low after a mid-frame
  // reset produces no spurious fall, so the cut frame cannot later raise frame_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave decoding 8-bit cmd + WIDTH data frames into NREGS registers.
// Latency: pin edges seen after 3 clk; writes commit (wr_stb, regs_out) 4 clk after the pin CS rise.
// Backpressure: none; the SPI master must respect SCLK <= clk/8 and 4-clk CS setup/hold.
// Ports: clk, rst_n (sync, active-low), spi (slave modport: sclk, cs, mosi, miso),
//        regs_out (reg i at [i*WIDTH +: WIDTH]), wr_stb, wr_addr, frame_err.
// Option: define SPI_REG_READBACK_EN to build the shift-out register and MISO path;
//         otherwise miso is tied 0 and read frames have no side effects.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_reg_bank_if.slave          spi,
  output logic [NREGS*WIDTH-1:0] regs_out,
  output logic                   wr_stb,
  output logic [ADDR_BITS-1:0]   wr_addr,
  output logic                   frame_err
);

  localparam int CNT_W = 6;
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi.sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(spi.cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi.mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [CMD_BITS-1:0] cmd_sr;
  logic [WIDTH-1:0]    data_sr;
  logic [WIDTH-1:0]    regs [NREGS];

  logic [CMD_BITS-1:0]  cmd_next;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic                 cmd_wr;
  logic [IDX_W-1:0]     cmd_idx;

  // cmd_next is the command as it will stand after the current SCLK rise;
  // the readback load at the 8th command bit needs the address before it is registered.
  assign cmd_next = {cmd_sr[CMD_BITS-2:0], mosi_lvl};
  assign cmd_addr = cmd_sr[ADDR_BITS-1:0];
  assign cmd_wr   = cmd_sr[CMD_WRITE_BIT];
  assign cmd_idx  = cmd_addr[IDX_W-1:0];

  // Priority per cycle: CS fall, then CS rise, then SCLK rise. A CS edge
  // coinciding with an SCLK edge swallows the SCLK edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      if (cs_fall) begin
        state <= CMD;
        cnt   <= '0;
      end else if (cs_rise) begin
        state <= IDLE;
        cnt   <= '0;
        case (state)
          DONE: begin
            if (cmd_wr && addr_in_range(cmd_addr, NREGS)) begin
              regs[cmd_idx] <= data_sr;
              wr_stb        <= 1'b1;
              wr_addr       <= cmd_addr;
            end
          end
          CMD, DATA: frame_err <= 1'b1;
          default: ;
        endcase
      end else if (sclk_rise) begin
        case (state)
          CMD: begin
            cmd_sr <= cmd_next;
            if (cnt == CNT_W'(CMD_BITS - 1)) begin
              state <= DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            data_sr <= {data_sr[WIDTH-2:0], mosi_lvl};
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_REG_READBACK_EN
  logic [WIDTH-1:0] sout;
  logic             miso_q;

  // Loaded on the last command bit; each falling edge while in DATA presents
  // the next bit MSB first. The fall after the last data bit lands in DONE and returns MISO to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sout   <= '0;
      miso_q <= 1'b0;
    end else if (cs_fall || cs_rise) begin
      miso_q <= 1'b0;
    end else if (sclk_rise && state == CMD && cnt == CNT_W'(CMD_BITS - 1)) begin
      sout <= addr_in_range(cmd_next[ADDR_BITS-1:0], NREGS) ? regs[cmd_next[IDX_W-1:0]] : '0;
    end else if (sclk_fall) begin
      if (state == DATA) begin
        miso_q <= sout[WIDTH-1];
        sout   <= {sout[WIDTH-2:0], 1'b0};
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  assign spi.miso = miso_q;
`else
  assign spi.miso = 1'b0;
`endif

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign regs_out[g*WIDTH +: WIDTH] = regs[g];
  end

  // Synchronizer outputs this block has no use for.
  logic unused_sync;
  assign unused_sync = ^{cs_lvl, sclk_lvl, sclk_fall, mosi_rise, mosi_fall};

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: drives SPI frames (directed + random) into spi_reg_bank and
// compares outputs against a frame-level register model every cycle.
module tb_spi_reg_bank;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREGS*WIDTH-1:0] regs_out;
  logic wr_stb;
  logic frame_err;
  logic [6:0] wr_addr;

  spi_reg_bank_if spi ();

  spi_reg_bank #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi(spi),
    .regs_out(regs_out),
    .wr_stb(wr_stb),
    .wr_addr(wr_addr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  bit started = 0;
  bit stable = 0;

  logic [WIDTH-1:0] m_regs [NREGS];
  logic [6:0] m_wr_addr;

  logic [7:0] last_rd;
  int last_stb_d;
  int last_err_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREGS*WIDTH-1:0] model_packed();
    logic [NREGS*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) v[i*WIDTH +: WIDTH] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_wr_addr = '0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle compare against the model whenever no commit is in flight.
  always @(negedge clk) begin
    if (started && rst_n && stable) begin
      chk("regs_out", 64'(regs_out), 64'(model_packed()));
      chk("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
      if (spi.cs === 1'b1) chk("miso_idle", 64'(spi.miso), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (started && rst_n) begin
      if (wr_stb === 1'b1) stb_cnt++;
      if (frame_err === 1'b1) err_cnt++;
    end
  end

  // nbits = number of SCLK pulses (16 = full frame, <16 aborts, 17 adds one in DONE).
  // do_rst pulses rst_n during the 3rd data bit and then ends the frame.
  task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input int nbits, input bit do_rst);
    logic [15:0] bits;
    logic [7:0] rd;
    logic [7:0] exp_rd;
    int stb0, err0, lat, a;
    bit full, commit;
    bits = {cmd, dat};
    rd = '0;
    stb0 = stb_cnt;
    err0 = err_cnt;
    a = int'(cmd[6:0]);
    spi.cs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      spi.mosi = (i < 16) ? bits[15-i] : 1'b0;
      wait_clk(8);
      if (i < 8) chk("miso_cmd", 64'(spi.miso), 64'd0);
      else if (i < 16) rd[15-i] = spi.miso;
      spi.sclk = 1'b1;
      if (do_rst && i == 10) begin
        wait_clk(3);
        rst_n = 1'b0;
        model_reset();
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(3);
        spi.sclk = 1'b0;
        break;
      end
      wait_clk(8);
      spi.sclk = 1'b0;
    end
    wait_clk(8);
    stable = 0;
    spi.cs = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (wr_stb === 1'b1 && lat == 0) lat = c;
    end
    full = !do_rst && nbits >= 16;
    commit = full && cmd[7] && (a < NREGS);
`ifdef SPI_REG_READBACK_EN
    exp_rd = (a < NREGS) ? m_regs[a] : 8'h00;
`else
    exp_rd = 8'h00;
`endif
    last_stb_d = stb_cnt - stb0;
    last_err_d = err_cnt - err0;
    last_rd = rd;
    chk("wr_stb_count", 64'(last_stb_d), commit ? 64'd1 : 64'd0);
    chk("frame_err_count", 64'(last_err_d), (!do_rst && nbits < 16) ? 64'd1 : 64'd0);
    if (commit) begin
      chk("wr_stb_latency_ok", 64'(lat >= 1 && lat <= 4), 64'd1);
      m_regs[a] = dat;
      m_wr_addr = cmd[6:0];
    end
    if (full && !cmd[7]) chk("miso_read", 64'(rd), 64'(exp_rd));
    stable = 1;
    wait_clk(8);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rc, rdat;
    int r, nb;
    spi.sclk = 1'b0;
    spi.cs = 1'b1;
    spi.mosi = 1'b0;
    model_reset();
    rst_n = 1'b0;
    wait_clk(2);
    chk("rst_regs_out", 64'(regs_out), 64'd0);
    chk("rst_miso", 64'(spi.miso), 64'd0);
    chk("rst_wr_stb", 64'(wr_stb), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    rst_n = 1'b1;
    started = 1;
    stable = 1;
    wait_clk(10);

    frame(8'h81, 8'hA5, 16, 0);
    chk("wr1_reg1", 64'(regs_out[15:8]), 64'hA5);
    chk("wr1_all", 64'(regs_out), 64'h0000A500);
    chk("wr1_addr", 64'(wr_addr), 64'd1);
    chk("wr1_one_stb", 64'(last_stb_d), 64'd1);

    frame(8'h01, 8'h00, 16, 0);
`ifdef SPI_REG_READBACK_EN
    chk("rd1_literal", 64'(last_rd), 64'hA5);
`else
    chk("rd1_literal", 64'(last_rd), 64'h00);
`endif
    chk("rd1_regs", 64'(regs_out), 64'h0000A500);

    frame(8'h82, 8'hF0, 12, 0);
    chk("abort_err", 64'(last_err_d), 64'd1);
    chk("abort_stb", 64'(last_stb_d), 64'd0);
    chk("abort_reg2", 64'(regs_out[23:16]), 64'h00);

    frame(8'h85, 8'hFF, 16, 0);
    chk("oor_stb", 64'(last_stb_d), 64'd0);
    chk("oor_regs", 64'(regs_out), 64'h0000A500);
    frame(8'h05, 8'h00, 16, 0);
    chk("oor_read", 64'(last_rd), 64'h00);

    for (int k = 0; k < 40; k++) begin
      rc = {1'($urandom_range(0, 1)), 4'b0000, 3'($urandom_range(0, 7))};
      rdat = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) nb = $urandom_range(0, 15);
      else if (r == 1) nb = 17;
      else nb = 16;
      frame(rc, rdat, nb, 0);
    end

    frame(8'h83, 8'h11, 16, 1);
    chk("rst_mid_err", 64'(last_err_d), 64'd0);
    chk("rst_mid_regs", 64'(regs_out), 64'd0);
    frame(8'h83, 8'h11, 16, 0);
    chk("post_rst_reg3", 64'(regs_out[31:24]), 64'h11);
    chk("post_rst_all", 64'(regs_out), 64'h11000000);
    chk("post_rst_stb", 64'(last_stb_d), 64'd1);
    chk("post_rst_err", 64'(last_err_d), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
